// File: rtl/fft16_stage_loader.sv
// rtl/fft16_stage_loader.sv - ping-pong frame buffer feeding stride-M sample groups to a radix-4 butterfly
module fft16_stage_loader #(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  localparam int M     = N / 4,
  localparam int GW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] x0_real,
  output logic [DATA_W-1:0] x0_imag,
  output logic [DATA_W-1:0] x1_real,
  output logic [DATA_W-1:0] x1_imag,
  output logic [DATA_W-1:0] x2_real,
  output logic [DATA_W-1:0] x2_imag,
  output logic [DATA_W-1:0] x3_real,
  output logic [DATA_W-1:0] x3_imag,
  output logic [GW-1:0]     m_group,
  output logic              m_last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] WR_LAST = CW'(N - 1);
  localparam logic [GW-1:0] RD_LAST = GW'(M - 1);

  // Sample storage: two banks of N complex samples, not reset.
  logic [DATA_W-1:0] bank_re [2][N];
  logic [DATA_W-1:0] bank_im [2][N];

  // Pointer and flag state.
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_cnt_q,  wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [GW-1:0] rd_grp_q,  rd_grp_d;
  logic [1:0]    full_q,    full_d;

  // Output register state.
  logic              m_valid_q, m_valid_d;
  logic              m_last_q,  m_last_d;
  logic [GW-1:0]     m_group_q, m_group_d;
  logic [DATA_W-1:0] x_re_q [4];
  logic [DATA_W-1:0] x_re_d [4];
  logic [DATA_W-1:0] x_im_q [4];
  logic [DATA_W-1:0] x_im_d [4];

  // Handshake decode.
  logic          ready_int;
  logic          accept;
  logic          wr_done;
  logic          load;
  logic          rd_done;

  // Read mux outputs for the group addressed by rd_bank/rd_grp.
  logic [CW-1:0]     lane_idx [4];
  logic [DATA_W-1:0] lane_re  [4];
  logic [DATA_W-1:0] lane_im  [4];

  // Select the four stride-M samples of the current read group.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = CW'(rd_grp_q) + CW'(k * M);
      lane_re[k]  = bank_re[rd_bank_q][lane_idx[k]];
      lane_im[k]  = bank_im[rd_bank_q][lane_idx[k]];
    end
  end

  // Pointer, full-flag and output-register next state.
  always_comb begin
    // s_ready depends only on registered state so m_ready never reaches it.
    ready_int = !full_q[wr_bank_q];
    accept    = s_valid && ready_int;
    wr_done   = accept && (wr_cnt_q == WR_LAST);
    load      = (!m_valid_q || m_ready) && full_q[rd_bank_q];
    rd_done   = load && (rd_grp_q == RD_LAST);

    wr_cnt_d  = wr_cnt_q;
    if (accept) begin
      wr_cnt_d = wr_done ? '0 : wr_cnt_q + CW'(1);
    end
    wr_bank_d = wr_bank_q ^ wr_done;

    rd_grp_d  = rd_grp_q;
    if (load) begin
      rd_grp_d = rd_done ? '0 : rd_grp_q + GW'(1);
    end
    rd_bank_d = rd_bank_q ^ rd_done;

    // The writer only fills a non-full bank and the reader only releases a
    // full one, so both updates always target different banks.
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;

    m_valid_d = m_valid_q;
    m_group_d = m_group_q;
    m_last_d  = m_last_q;
    for (int k = 0; k < 4; k++) begin
      x_re_d[k] = x_re_q[k];
      x_im_d[k] = x_im_q[k];
    end
    if (load) begin
      m_valid_d = 1'b1;
      m_group_d = rd_grp_q;
      m_last_d  = (rd_grp_q == RD_LAST);
      for (int k = 0; k < 4; k++) begin
        x_re_d[k] = lane_re[k];
        x_im_d[k] = lane_im[k];
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Write accepted samples into the active fill bank.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_re[wr_bank_q][wr_cnt_q] <= s_real;
      bank_im[wr_bank_q][wr_cnt_q] <= s_imag;
    end
  end

  // State register with synchronous reset; partial frames are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_grp_q  <= '0;
      full_q    <= 2'b00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_group_q <= '0;
      for (int k = 0; k < 4; k++) begin
        x_re_q[k] <= '0;
        x_im_q[k] <= '0;
      end
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_grp_q  <= rd_grp_d;
      full_q    <= full_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_group_q <= m_group_d;
      for (int k = 0; k < 4; k++) begin
        x_re_q[k] <= x_re_d[k];
        x_im_q[k] <= x_im_d[k];
      end
    end
  end

  assign s_ready = ready_int;
  assign m_valid = m_valid_q;
  assign m_group = m_group_q;
  assign m_last  = m_last_q;
  assign x0_real = x_re_q[0];
  assign x0_imag = x_im_q[0];
  assign x1_real = x_re_q[1];
  assign x1_imag = x_im_q[1];
  assign x2_real = x_re_q[2];
  assign x2_imag = x_im_q[2];
  assign x3_real = x_re_q[3];
  assign x3_imag = x_im_q[3];

endmodule

// File: tb/tb_fft16_stage_loader.sv
// tb/tb_fft16_stage_loader.sv - directed and random-stall bench for fft16_stage_loader
module tb_fft16_stage_loader;

  localparam int OW = 8 * 16 + 2 + 1;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_real;
  logic [15:0] s_imag;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] x0_real, x0_imag, x1_real, x1_imag;
  logic [15:0] x2_real, x2_imag, x3_real, x3_imag;
  logic [1:0]  m_group;
  logic        m_last;

  fft16_stage_loader #(.DATA_W(16), .N(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_real  (s_real),
    .s_imag  (s_imag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .x0_real (x0_real),
    .x0_imag (x0_imag),
    .x1_real (x1_real),
    .x1_imag (x1_imag),
    .x2_real (x2_real),
    .x2_imag (x2_imag),
    .x3_real (x3_real),
    .x3_imag (x3_imag),
    .m_group (m_group),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {x0_real, x0_imag, x1_real, x1_imag, x2_real, x2_imag,
                x3_real, x3_imag, m_group, m_last};

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  int cyc    = 0;

  // Reference samples in acceptance order since the last reset.
  logic [15:0] mdl_re [0:511];
  logic [15:0] mdl_im [0:511];

  // Expected output group j: frame j/4, group g, lanes at g, g+4, g+8, g+12.
  function automatic logic [OW-1:0] expected_group(input int j);
    int f, g, b;
    f = j / 4;
    g = j % 4;
    b = f * 16 + g;
    return {mdl_re[b], mdl_im[b], mdl_re[b+4], mdl_im[b+4],
            mdl_re[b+8], mdl_im[b+8], mdl_re[b+12], mdl_im[b+12],
            2'(g), (g == 3)};
  endfunction

  // One clock: sample DUT at the negedge, then move to just after the posedge.
  task automatic step(output logic acc, output logic got, output logic mv,
                      output logic sr, output logic [OW-1:0] o,
                      output int oidx, output int c);
    @(negedge clk);
    sr   = s_ready;
    mv   = m_valid;
    acc  = s_valid && s_ready;
    got  = m_valid && m_ready;
    o    = obs;
    oidx = n_out;
    c    = cyc;
    cyc++;
    if (acc) n_in++;
    if (got) n_out++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    n_in  = 0;
    n_out = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_valid: got %b expected 0", m_valid);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b expected 1", s_ready);
    end
  endtask

  task automatic test_single_frame();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    logic [OW-1:0] g0, g3;
    int oidx, c, c15, first_v, idle;
    g0 = {16'd0, 16'd0, 16'd4, 16'hFFFC, 16'd8, 16'hFFF8, 16'd12, 16'hFFF4, 2'd0, 1'b0};
    g3 = {16'd3, 16'hFFFD, 16'd7, 16'hFFF9, 16'd11, 16'hFFF5, 16'd15, 16'hFFF1, 2'd3, 1'b1};
    do_reset();
    for (int n = 0; n < 16; n++) begin
      mdl_re[n] = 16'(n);
      mdl_im[n] = 16'(-n);
    end
    c15 = -100;
    first_v = -1;
    idle = 0;
    m_ready = 1'b1;
    for (int t = 0; t < 60 && idle < 3; t++) begin
      s_valid = (n_in < 16);
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      if (acc && n_in == 16) c15 = c;
      if (mv && first_v < 0) first_v = c;
      if (n_out == 4) idle++;
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL single_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
        if (oidx == 0) begin
          checks++;
          if (o !== g0) begin
            errors++;
            $display("FAIL single_g0_const: got %h expected %h", o, g0);
          end
        end
        if (oidx == 3) begin
          checks++;
          if (o !== g3) begin
            errors++;
            $display("FAIL single_g3_const: got %h expected %h", o, g3);
          end
        end
      end
    end
    checks++;
    if (first_v != c15 + 2) begin
      errors++;
      $display("FAIL single_latency: got first valid cycle %0d expected %0d", first_v, c15 + 2);
    end
    checks++;
    if (n_out != 4 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got %0d groups valid=%b expected 4 groups valid=0", n_out, m_valid);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    int oidx, c, drops;
    do_reset();
    for (int n = 0; n < 64; n++) begin
      mdl_re[n] = 16'(n * 37 + 5);
      mdl_im[n] = 16'(~(n * 11));
    end
    drops = 0;
    m_ready = 1'b1;
    for (int t = 0; t < 200 && n_out < 16; t++) begin
      s_valid = (n_in < 64);
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      if (s_valid && !sr) drops++;
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL stream_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
      end
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL stream_s_ready: got %0d stall cycles expected 0", drops);
    end
    checks++;
    if (n_out != 16 || n_in != 64) begin
      errors++;
      $display("FAIL stream_count: got %0d groups %0d samples expected 16 and 64", n_out, n_in);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    int oidx, c;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      mdl_re[n] = 16'(16'h1000 + n);
      mdl_im[n] = 16'(16'hA000 - n * 3);
    end
    m_ready = 1'b0;
    for (int t = 0; t < 80 && n_in < 32; t++) begin
      s_valid = 1'b1;
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
    end
    for (int t = 0; t < 4; t++) begin
      s_valid = 1'b1;
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      checks++;
      if (sr !== 1'b0 || mv !== 1'b1 || o !== expected_group(0)) begin
        errors++;
        $display("FAIL bp_hold: got ready=%b valid=%b out=%h expected ready=0 valid=1 out=%h",
                 sr, mv, o, expected_group(0));
      end
    end
    checks++;
    if (n_in != 32) begin
      errors++;
      $display("FAIL bp_accepted: got %0d samples expected 32", n_in);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 30 && n_out < 8; t++) begin
      step(acc, got, mv, sr, o, oidx, c);
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL bp_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
        if (oidx == 2 || oidx == 3) begin
          checks++;
          if (sr !== (oidx == 3)) begin
            errors++;
            $display("FAIL bp_s_ready_at_group%0d: got %b expected %b", oidx, sr, (oidx == 3));
          end
        end
      end
    end
    checks++;
    if (n_out != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d groups expected 8", n_out);
    end
  endtask

  task automatic test_random_stall();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    int oidx, c;
    do_reset();
    for (int n = 0; n < 320; n++) begin
      mdl_re[n] = 16'($urandom);
      mdl_im[n] = 16'($urandom);
    end
    for (int t = 0; t < 4000 && n_out < 80; t++) begin
      s_valid = (n_in < 320) && ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 1) == 1);
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL rand_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step(acc, got, mv, sr, o, oidx, c);
    end
    checks++;
    if (n_out != 80 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_count: got %0d groups valid=%b expected 80 groups valid=0", n_out, m_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    int oidx, c;
    do_reset();
    m_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      mdl_re[n] = 16'h5555;
      mdl_im[n] = 16'hAAAA;
    end
    for (int t = 0; t < 20 && n_in < 7; t++) begin
      s_valid = 1'b1;
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_in = 0;
    n_out = 0;
    checks++;
    if (obs !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got out=%h valid=%b ready=%b expected 0 0 1", obs, m_valid, s_ready);
    end
    for (int n = 0; n < 16; n++) begin
      mdl_re[n] = 16'(16'h0300 + n * 7);
      mdl_im[n] = 16'(16'hF100 + n);
    end
    for (int t = 0; t < 60 && n_out < 4; t++) begin
      s_valid = (n_in < 16);
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL midreset_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
      end
    end
    s_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step(acc, got, mv, sr, o, oidx, c);
    end
    checks++;
    if (n_out != 4 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_count: got %0d groups valid=%b expected 4 groups valid=0", n_out, m_valid);
    end
  endtask

  task automatic test_extremes();
    logic acc, got, mv, sr;
    logic [OW-1:0] o;
    logic [OW-1:0] g0;
    int oidx, c;
    g0 = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 2'd0, 1'b0};
    do_reset();
    for (int n = 0; n < 16; n++) begin
      mdl_re[n] = (((n / 4) % 2) == 1) ? 16'h7FFF : 16'h8000;
      mdl_im[n] = (((n / 4) % 2) == 1) ? 16'h8000 : 16'h7FFF;
    end
    m_ready = 1'b1;
    for (int t = 0; t < 60 && n_out < 4; t++) begin
      s_valid = (n_in < 16);
      s_real  = mdl_re[n_in];
      s_imag  = mdl_im[n_in];
      step(acc, got, mv, sr, o, oidx, c);
      if (got) begin
        checks++;
        if (o !== expected_group(oidx)) begin
          errors++;
          $display("FAIL extreme_group%0d: got %h expected %h", oidx, o, expected_group(oidx));
        end
        if (oidx == 0) begin
          checks++;
          if (o !== g0) begin
            errors++;
            $display("FAIL extreme_g0_const: got %h expected %h", o, g0);
          end
        end
      end
    end
    checks++;
    if (n_out != 4) begin
      errors++;
      $display("FAIL extreme_count: got %0d groups expected 4", n_out);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    test_reset();
    test_single_frame();
    test_streaming();
    test_backpressure();
    test_random_stall();
    test_reset_mid_frame();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
